// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation driven by a registered hall code, with a shared-counter
// complementary PWM and dead-time insertion on every per-phase drive change.
module bldc_commutator #(
  parameter int  PHASE_DRIVER_MAX_COUNTER = 'h1FF,
  parameter int  MAX_DUTY_CYCLE           = 'h1FF,
  parameter int  DUTY_CYCLE_STEP_RES      = 1,
  parameter int  DEAD_TIME                = 2,
  localparam int DW = (MAX_DUTY_CYCLE > 0) ? $clog2(MAX_DUTY_CYCLE + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    hall,
  input  logic [DW-1:0] duty_cycle,
  output logic [2:0]    phaseH,
  output logic [2:0]    phaseL
);

  localparam int CW = (PHASE_DRIVER_MAX_COUNTER > 0) ? $clog2(PHASE_DRIVER_MAX_COUNTER + 1) : 1;
  localparam int RW = $clog2(DUTY_CYCLE_STEP_RES + 1);
  localparam int MW = ((DW + RW) > CW) ? (DW + RW) : CW;
  localparam int TW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(PHASE_DRIVER_MAX_COUNTER);
  // The cycle that detects a change is itself the first gap cycle.
  localparam logic [TW-1:0] DT_LOAD = (DEAD_TIME > 0) ? TW'(DEAD_TIME - 1) : '0;

  typedef enum logic [1:0] {
    REQ_OFF = 2'd0,
    REQ_HI  = 2'd1,
    REQ_LO  = 2'd2
  } req_e;

  logic [2:0]    hall_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] duty_ext, eff_duty;
  logic          pwm_on;
  logic [2:0]    hi_sel, lo_sel;
  req_e          req [3];
  req_e          prev_req_q [3];
  req_e          prev_req_d [3];
  logic [TW-1:0] dt_q [3];
  logic [TW-1:0] dt_d [3];
  logic [2:0]    phase_h_q, phase_h_d;
  logic [2:0]    phase_l_q, phase_l_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    hi_sel = 3'b000;
    lo_sel = 3'b000;
    case (hall_s_q)
      3'b101:  begin hi_sel = 3'b001; lo_sel = 3'b010; end
      3'b100:  begin hi_sel = 3'b001; lo_sel = 3'b100; end
      3'b110:  begin hi_sel = 3'b010; lo_sel = 3'b100; end
      3'b010:  begin hi_sel = 3'b010; lo_sel = 3'b001; end
      3'b011:  begin hi_sel = 3'b100; lo_sel = 3'b001; end
      3'b001:  begin hi_sel = 3'b100; lo_sel = 3'b010; end
      default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
    endcase
  end

  always_comb begin
    duty_ext = MW'(duty_cycle);
    if (duty_ext > MW'(MAX_DUTY_CYCLE)) duty_ext = MW'(MAX_DUTY_CYCLE);
    eff_duty = duty_ext * MW'(DUTY_CYCLE_STEP_RES);
    pwm_on   = MW'(cnt_q) < eff_duty;
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      req[j] = REQ_OFF;
      if (en && hi_sel[j])      req[j] = pwm_on ? REQ_HI : REQ_LO;
      else if (en && lo_sel[j]) req[j] = REQ_LO;
    end
  end

  always_comb begin
    phase_h_d = 3'b000;
    phase_l_d = 3'b000;
    for (int j = 0; j < 3; j++) begin
      prev_req_d[j] = req[j];
      dt_d[j]       = dt_q[j];
      if (req[j] != prev_req_q[j]) begin
        dt_d[j] = DT_LOAD;
        if (DEAD_TIME == 0) begin
          phase_h_d[j] = (req[j] == REQ_HI);
          phase_l_d[j] = (req[j] == REQ_LO);
        end
      end else if (dt_q[j] != '0) begin
        dt_d[j] = dt_q[j] - TW'(1);
      end else begin
        phase_h_d[j] = (req[j] == REQ_HI);
        phase_l_d[j] = (req[j] == REQ_LO);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      hall_s_q  <= 3'b000;
      cnt_q     <= '0;
      phase_h_q <= 3'b000;
      phase_l_q <= 3'b000;
      for (int j = 0; j < 3; j++) begin
        prev_req_q[j] <= REQ_OFF;
        dt_q[j]       <= '0;
      end
    end else begin
      hall_s_q  <= hall;
      cnt_q     <= cnt_d;
      phase_h_q <= phase_h_d;
      phase_l_q <= phase_l_d;
      for (int j = 0; j < 3; j++) begin
        prev_req_q[j] <= prev_req_d[j];
        dt_q[j]       <= dt_d[j];
      end
    end
  end

  assign phaseH = phase_h_q;
  assign phaseL = phase_l_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: three instances (defaults, step resolution 2, zero dead time)
// against a run-length reference model via an expectation queue, plus directed checks.
module tb_bldc_commutator;

  localparam int NI     = 3;
  localparam int PERIOD = 512;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [2:0]           hall;
  logic [8:0]           duty;
  logic [NI-1:0][2:0]   ph;
  logic [NI-1:0][2:0]   pl;

  int checks = 0;
  int errors = 0;

  bldc_commutator u0 (
    .clk(clk), .rst(rst), .en(en), .hall(hall), .duty_cycle(duty),
    .phaseH(ph[0]), .phaseL(pl[0])
  );

  bldc_commutator #(.DUTY_CYCLE_STEP_RES(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .hall(hall), .duty_cycle(duty),
    .phaseH(ph[1]), .phaseL(pl[1])
  );

  bldc_commutator #(.DEAD_TIME(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .hall(hall), .duty_cycle(duty),
    .phaseH(ph[2]), .phaseL(pl[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dt_of(int k);
    return (k == 2) ? 0 : 2;
  endfunction

  function automatic int res_of(int k);
    return (k == 1) ? 2 : 1;
  endfunction

  typedef struct packed {
    logic [NI-1:0][2:0] h;
    logic [NI-1:0][2:0] l;
  } exp_t;

  exp_t exp_q[$];

  // Reference: a phase drives its request only once that request has been stable
  // for more than DEAD_TIME consecutive evaluations; OFF always drives nothing.
  logic [2:0] m_hall_s;
  int         m_cnt;
  int         m_prev [NI][3];
  int         m_run  [NI][3];

  always @(posedge clk) begin
    exp_t e;
    int   hi_i, lo_i, dv, eff, rq;
    e = '0;
    if (rst) begin
      m_hall_s = 3'b000;
      m_cnt    = 0;
      for (int k = 0; k < NI; k++)
        for (int j = 0; j < 3; j++) begin
          m_prev[k][j] = 0;
          m_run[k][j]  = 99;
        end
    end else begin
      case (m_hall_s)
        3'b101:  begin hi_i = 0;  lo_i = 1;  end
        3'b100:  begin hi_i = 0;  lo_i = 2;  end
        3'b110:  begin hi_i = 1;  lo_i = 2;  end
        3'b010:  begin hi_i = 1;  lo_i = 0;  end
        3'b011:  begin hi_i = 2;  lo_i = 0;  end
        3'b001:  begin hi_i = 2;  lo_i = 1;  end
        default: begin hi_i = -1; lo_i = -1; end
      endcase
      dv = int'(duty);
      if (dv > 511) dv = 511;
      for (int k = 0; k < NI; k++) begin
        eff = dv * res_of(k);
        for (int j = 0; j < 3; j++) begin
          if (!en)           rq = 0;
          else if (j == hi_i) rq = (m_cnt < eff) ? 1 : 2;
          else if (j == lo_i) rq = 2;
          else                rq = 0;
          if (rq == m_prev[k][j]) m_run[k][j] = (m_run[k][j] < 99) ? m_run[k][j] + 1 : 99;
          else                    m_run[k][j] = 1;
          m_prev[k][j] = rq;
          if (m_run[k][j] > dt_of(k)) begin
            e.h[k][j] = (rq == 1);
            e.l[k][j] = (rq == 2);
          end
        end
      end
      m_hall_s = hall;
      m_cnt    = (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (ph[k] !== e.h[k] || pl[k] !== e.l[k]) begin
          errors++;
          $display("FAIL scoreboard u%0d t=%0t: phaseH/L=%b/%b expected %b/%b",
                   k, $time, ph[k], pl[k], e.h[k], e.l[k]);
        end
        checks++;
        if ((ph[k] & pl[k]) !== 3'b000) begin
          errors++;
          $display("FAIL shoot_through u%0d t=%0t: phaseH&phaseL=%b expected 000",
                   k, $time, ph[k] & pl[k]);
        end
      end
    end
  end

  task automatic test_reset();
    int   first_n [NI];
    logic [2:0] first_l [NI];
    rst = 1'b1; hall = 3'b101; en = 1'b1; duty = 9'd100;
    repeat (6) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (ph[k] !== 3'b000 || pl[k] !== 3'b000) begin
          errors++;
          $display("FAIL reset_hold u%0d: phaseH/L=%b/%b expected 000/000", k, ph[k], pl[k]);
        end
      end
    end
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin first_n[k] = 0; first_l[k] = 3'b000; end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++)
        if (first_n[k] == 0 && (ph[k] | pl[k]) !== 3'b000) begin
          first_n[k] = n;
          first_l[k] = pl[k];
        end
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (first_n[k] != 2 + dt_of(k)) begin
        errors++;
        $display("FAIL reset_first_drive u%0d: first nonzero at edge %0d expected %0d",
                 k, first_n[k], 2 + dt_of(k));
      end
      checks++;
      if (first_l[k] !== 3'b010) begin
        errors++;
        $display("FAIL reset_first_low u%0d: phaseL=%b expected 010", k, first_l[k]);
      end
    end
  endtask

  task automatic test_commutation();
    logic [2:0] codes [6];
    logic [2:0] eh [6];
    logic [2:0] el [6];
    codes = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    eh    = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    el    = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
    en = 1'b1; duty = 9'd511;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hall = codes[i];
      repeat (8) @(negedge clk);
      checks++;
      if (ph[1] !== eh[i] || pl[1] !== el[i]) begin
        errors++;
        $display("FAIL commutation hall=%b u1: phaseH/L=%b/%b expected %b/%b",
                 codes[i], ph[1], pl[1], eh[i], el[i]);
      end
      checks++;
      if ((pl[0] & el[i]) !== el[i] || ((ph[0] | pl[0]) & ~(eh[i] | el[i])) !== 3'b000) begin
        errors++;
        $display("FAIL commutation hall=%b u0: phaseH/L=%b/%b expected low %b, float %b",
                 codes[i], ph[0], pl[0], el[i], ~(eh[i] | el[i]));
      end
    end
  endtask

  task automatic test_invalid_codes();
    logic [2:0] bad [2];
    bad = '{3'b000, 3'b111};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      hall = 3'b011;
      repeat (8) @(negedge clk);
      hall = bad[i];
      @(negedge clk);
      checks++;
      if (ph[1] !== 3'b100 || pl[1] !== 3'b001) begin
        errors++;
        $display("FAIL invalid_latency hall=%b u1: phaseH/L=%b/%b expected 100/001 one edge after",
                 bad[i], ph[1], pl[1]);
      end
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (ph[k] !== 3'b000 || pl[k] !== 3'b000) begin
          errors++;
          $display("FAIL invalid_float hall=%b u%0d: phaseH/L=%b/%b expected 000/000",
                   bad[i], k, ph[k], pl[k]);
        end
      end
    end
  endtask

  task automatic test_pwm();
    int hc [NI], lc [NI], cc [NI], bc [NI];
    int eh [NI], el [NI];
    eh = '{126, 254, 128};
    el = '{382, 254, 384};
    @(negedge clk);
    hall = 3'b100; duty = 9'd128; en = 1'b1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < NI; k++) begin hc[k] = 0; lc[k] = 0; cc[k] = 0; bc[k] = 0; end
    repeat (PERIOD) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        hc[k] += int'(ph[k][0]);
        lc[k] += int'(pl[k][0]);
        cc[k] += int'(pl[k][2]);
        bc[k] += int'(ph[k][1] | pl[k][1]);
      end
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (hc[k] != eh[k]) begin
        errors++;
        $display("FAIL pwm_high u%0d: phaseH[A] on %0d clocks expected %0d", k, hc[k], eh[k]);
      end
      checks++;
      if (lc[k] != el[k]) begin
        errors++;
        $display("FAIL pwm_low u%0d: phaseL[A] on %0d clocks expected %0d", k, lc[k], el[k]);
      end
      checks++;
      if (cc[k] != PERIOD || bc[k] != 0) begin
        errors++;
        $display("FAIL pwm_other u%0d: C low %0d clocks (expected %0d), B driven %0d (expected 0)",
                 k, cc[k], PERIOD, bc[k]);
      end
    end
  endtask

  task automatic test_duty_extremes();
    int bad0, bad2, bad1, hc0, lc0;
    @(negedge clk);
    duty = 9'd0;
    repeat (10) @(negedge clk);
    bad0 = 0; bad2 = 0;
    repeat (600) begin
      @(negedge clk);
      if (ph[0] !== 3'b000 || pl[0] !== 3'b101) bad0++;
      if (ph[2] !== 3'b000 || pl[2] !== 3'b101) bad2++;
    end
    checks++;
    if (bad0 != 0 || bad2 != 0) begin
      errors++;
      $display("FAIL duty_zero: %0d/%0d cycles not 000/101 on u0/u2, expected 0/0", bad0, bad2);
    end
    @(negedge clk);
    duty = 9'd511;
    repeat (10) @(negedge clk);
    bad1 = 0; hc0 = 0; lc0 = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (ph[1] !== 3'b001 || pl[1] !== 3'b100) bad1++;
      hc0 += int'(ph[0][0]);
      lc0 += int'(pl[0][0]);
    end
    checks++;
    if (bad1 != 0) begin
      errors++;
      $display("FAIL duty_full_res2: %0d cycles not 001/100 on u1, expected 0", bad1);
    end
    checks++;
    if (hc0 != 509 || lc0 != 0) begin
      errors++;
      $display("FAIL duty_511_res1: u0 A high %0d low %0d clocks, expected 509 and 0", hc0, lc0);
    end
  endtask

  task automatic test_enable_toggle();
    @(negedge clk);
    hall = 3'b100; duty = 9'd128; en = 1'b1;
    repeat (40) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (ph[k] !== 3'b000 || pl[k] !== 3'b000) begin
        errors++;
        $display("FAIL en_drop u%0d: phaseH/L=%b/%b expected 000/000", k, ph[k], pl[k]);
      end
    end
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (ph[0] !== 3'b000 || pl[0] !== 3'b000) begin
      errors++;
      $display("FAIL en_restore_gap1 u0: phaseH/L=%b/%b expected 000/000", ph[0], pl[0]);
    end
    checks++;
    if (pl[2][2] !== 1'b1) begin
      errors++;
      $display("FAIL en_restore_direct u2: phaseL=%b expected C low (1xx)", pl[2]);
    end
    @(negedge clk);
    checks++;
    if (ph[0] !== 3'b000 || pl[0] !== 3'b000) begin
      errors++;
      $display("FAIL en_restore_gap2 u0: phaseH/L=%b/%b expected 000/000", ph[0], pl[0]);
    end
    @(negedge clk);
    checks++;
    if (pl[0][2] !== 1'b1 || (ph[0][1] | pl[0][1]) !== 1'b0) begin
      errors++;
      $display("FAIL en_restore_resume u0: phaseH/L=%b/%b expected C low, B float", ph[0], pl[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    hall = 3'b010; duty = 9'd300; en = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (ph[k] !== 3'b000 || pl[k] !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid u%0d: phaseH/L=%b/%b expected 000/000", k, ph[k], pl[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) hall = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) duty = 9'($urandom_range(0, 511));
      en  = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; hall = 3'b000; duty = 9'd0;
    test_reset();
    test_commutation();
    test_invalid_codes();
    test_pwm();
    test_duty_extremes();
    test_enable_toggle();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
